// File: rtl/rr_mult_pkg.sv
// Shared widths, split helper and pipeline payload type for the recursive-split multiplier.
package rr_mult_pkg;

    localparam int unsigned RR_W     = 8;
    localparam int unsigned RR_L     = 2;
    localparam int unsigned RR_APX_K = 2;
    localparam int unsigned RR_ERR_W = 16;

    function automatic int unsigned split_hi_w(input int unsigned w, input int unsigned l);
        return w - l;
    endfunction

    localparam int unsigned RR_H    = split_hi_w(RR_W, RR_L);
    localparam int unsigned PP_HH_W = 2 * RR_H;
    localparam int unsigned PP_HL_W = RR_H + RR_L;
    localparam int unsigned PP_LL_W = 2 * RR_L;
    localparam int unsigned XSUM_W  = RR_H + RR_L + 1;
    localparam int unsigned PROD_W  = 2 * RR_W;

    // Operand beat as captured by the first pipeline stage.
    typedef struct packed {
        logic [RR_W-1:0] a;
        logic [RR_W-1:0] b;
        logic            apx;
    } rr_payload_t;

endpackage

// File: rtl/rr_mult_pipe_if.sv
// Operand/product stream and error-monitor signals of rr_mult_pipe.
interface rr_mult_pipe_if #(
    parameter int unsigned W     = rr_mult_pkg::RR_W,
    parameter int unsigned ERR_W = rr_mult_pkg::RR_ERR_W
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic             in_apx;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_p;
    logic             out_apx;
    logic             err_clr;
    logic [ERR_W-1:0] err_cnt;
    logic [2*W-1:0]   err_max;

    modport master (
        output in_valid, in_a, in_b, in_apx, out_ready, err_clr,
        input  in_ready, out_valid, out_p, out_apx, err_cnt, err_max
    );

    modport slave (
        input  in_valid, in_a, in_b, in_apx, out_ready, err_clr,
        output in_ready, out_valid, out_p, out_apx, err_cnt, err_max
    );
endinterface

// File: rtl/rr_split_pp.sv
// Combinational generator of the four high/low partial products of a W x W split multiply.
module rr_split_pp
    import rr_mult_pkg::*;
#(
    parameter int unsigned W = RR_W,
    parameter int unsigned L = RR_L
) (
    input  logic [W-1:0]         a_i,
    input  logic [W-1:0]         b_i,
    output logic [2*(W-L)-1:0]   p1_o,
    output logic [W-1:0]         p2_o,
    output logic [W-1:0]         p3_o,
    output logic [2*L-1:0]       p4_o
);
    localparam int unsigned H    = split_hi_w(W, L);
    localparam int unsigned HH_W = 2 * H;
    localparam int unsigned LL_W = 2 * L;

    logic [H-1:0] ah;
    logic [H-1:0] bh;
    logic [L-1:0] al;
    logic [L-1:0] bl;

    assign ah = a_i[W-1:L];
    assign al = a_i[L-1:0];
    assign bh = b_i[W-1:L];
    assign bl = b_i[L-1:0];

    assign p1_o = HH_W'(ah) * HH_W'(bh);
    assign p2_o = W'(ah) * W'(bl);
    assign p3_o = W'(al) * W'(bh);
    assign p4_o = LL_W'(al) * LL_W'(bl);

endmodule

// File: rtl/rr_mult_pipe.sv
// Three-stage W x W unsigned multiplier with one high/low split and per-beat approximate cross-term add.
// Define ERR_MON_EN to build the exact-product shadow path and the error monitor.
module rr_mult_pipe
    import rr_mult_pkg::*;
#(
    parameter int unsigned W     = RR_W,
    parameter int unsigned L     = RR_L,
    parameter int unsigned APX_K = RR_APX_K,
    parameter int unsigned ERR_W = RR_ERR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    rr_mult_pipe_if.slave bus
);
    localparam int unsigned H    = split_hi_w(W, L);
    localparam int unsigned HH_W = 2 * H;
    localparam int unsigned HL_W = H + L;
    localparam int unsigned LL_W = 2 * L;
    localparam int unsigned X_W  = H + L + 1;
    localparam int unsigned P_W  = 2 * W;

    function automatic logic [P_W-1:0] merge_pp(input logic [HH_W-1:0] p1,
                                                input logic [X_W-1:0]  x,
                                                input logic [LL_W-1:0] p4);
        return (P_W'(p1) << (2 * L)) + (P_W'(x) << L) + P_W'(p4);
    endfunction

    // A stalled output freezes every stage at once.
    logic stall;
    logic en;
    assign stall        = bus.out_valid && !bus.out_ready;
    assign en           = !stall;
    assign bus.in_ready = en;

    // S1: operand capture
    rr_payload_t s1_d;
    rr_payload_t s1_q;
    logic        v1_q;

    assign s1_d = '{a: bus.in_a, b: bus.in_b, apx: bus.in_apx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            s1_q <= '0;
        end else if (en) begin
            v1_q <= bus.in_valid;
            if (bus.in_valid) s1_q <= s1_d;
        end
    end

    // S2: partial products
    logic [HH_W-1:0] pp1_c;
    logic [HL_W-1:0] pp2_c;
    logic [HL_W-1:0] pp3_c;
    logic [LL_W-1:0] pp4_c;
    logic [HH_W-1:0] p1_q;
    logic [HL_W-1:0] p2_q;
    logic [HL_W-1:0] p3_q;
    logic [LL_W-1:0] p4_q;
    logic            apx2_q;
    logic            v2_q;

    rr_split_pp #(.W(W), .L(L)) u_pp (
        .a_i  (s1_q.a),
        .b_i  (s1_q.b),
        .p1_o (pp1_c),
        .p2_o (pp2_c),
        .p3_o (pp3_c),
        .p4_o (pp4_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q   <= 1'b0;
            apx2_q <= 1'b0;
            p1_q   <= '0;
            p2_q   <= '0;
            p3_q   <= '0;
            p4_q   <= '0;
        end else if (en) begin
            v2_q <= v1_q;
            if (v1_q) begin
                apx2_q <= s1_q.apx;
                p1_q   <= pp1_c;
                p2_q   <= pp2_c;
                p3_q   <= pp3_c;
                p4_q   <= pp4_c;
            end
        end
    end

    // S3: cross-term add; approx mode ORs the low APX_K bits and drops their carry.
    logic [X_W-1:0] x_exact_c;
    logic [X_W-1:0] x_apx_c;
    logic [X_W-1:0] x_sel_c;
    logic [P_W-1:0] prod_d;

    assign x_exact_c = X_W'(p2_q) + X_W'(p3_q);

    generate
        if (APX_K == 0) begin : g_no_apx
            assign x_apx_c = x_exact_c;
        end else begin : g_apx
            localparam int unsigned XH_W = X_W - APX_K;
            assign x_apx_c = {XH_W'(p2_q[HL_W-1:APX_K]) + XH_W'(p3_q[HL_W-1:APX_K]),
                              p2_q[APX_K-1:0] | p3_q[APX_K-1:0]};
        end
    endgenerate

    assign x_sel_c = apx2_q ? x_apx_c : x_exact_c;
    assign prod_d  = merge_pp(p1_q, x_sel_c, p4_q);

    logic           out_valid_q;
    logic [P_W-1:0] out_p_q;
    logic           out_apx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_apx_q   <= 1'b0;
        end else if (en) begin
            out_valid_q <= v2_q;
            if (v2_q) begin
                out_p_q   <= prod_d;
                out_apx_q <= apx2_q;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_p     = out_p_q;
    assign bus.out_apx   = out_apx_q;

`ifdef ERR_MON_EN
    // Exact shadow path, aligned stage-for-stage with the main datapath.
    logic [HH_W-1:0] ep1_c;
    logic [HL_W-1:0] ep2_c;
    logic [HL_W-1:0] ep3_c;
    logic [LL_W-1:0] ep4_c;
    logic [HH_W-1:0] ep1_q;
    logic [HL_W-1:0] ep2_q;
    logic [HL_W-1:0] ep3_q;
    logic [LL_W-1:0] ep4_q;
    logic [P_W-1:0]  exact_d;
    logic [P_W-1:0]  exact_q;

    rr_split_pp #(.W(W), .L(L)) u_pp_exact (
        .a_i  (s1_q.a),
        .b_i  (s1_q.b),
        .p1_o (ep1_c),
        .p2_o (ep2_c),
        .p3_o (ep3_c),
        .p4_o (ep4_c)
    );

    assign exact_d = merge_pp(ep1_q, X_W'(ep2_q) + X_W'(ep3_q), ep4_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ep1_q   <= '0;
            ep2_q   <= '0;
            ep3_q   <= '0;
            ep4_q   <= '0;
            exact_q <= '0;
        end else if (en) begin
            if (v1_q) begin
                ep1_q <= ep1_c;
                ep2_q <= ep2_c;
                ep3_q <= ep3_c;
                ep4_q <= ep4_c;
            end
            if (v2_q) exact_q <= exact_d;
        end
    end

    // Error monitor: clear has priority over a coincident update.
    logic [ERR_W-1:0] err_cnt_d;
    logic [ERR_W-1:0] err_cnt_q;
    logic [P_W-1:0]   err_max_d;
    logic [P_W-1:0]   err_max_q;
    logic [P_W-1:0]   diff_c;

    assign diff_c = exact_q - out_p_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        err_max_d = err_max_q;
        if (bus.err_clr) begin
            err_cnt_d = '0;
            err_max_d = '0;
        end else if (out_valid_q && bus.out_ready && (diff_c != '0)) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (diff_c > err_max_q) err_max_d = diff_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
            err_max_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_max_q <= err_max_d;
        end
    end

    assign bus.err_cnt = err_cnt_q;
    assign bus.err_max = err_max_q;
`else
    assign bus.err_cnt = '0;
    assign bus.err_max = '0;
`endif

endmodule

// File: tb/tb_rr_mult_pipe.sv
// Self-checking bench for rr_mult_pipe: directed corners plus randomized streams against an arithmetic model.
module tb_rr_mult_pipe;
    import rr_mult_pkg::*;

    localparam int unsigned W     = 8;
    localparam int unsigned L     = 2;
    localparam int unsigned APX_K = 2;
    localparam int unsigned ERR_W = 16;
    localparam int unsigned PW    = 2 * W;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    // Expected {apx, product} in output order.
    logic [PW:0] exp_q[$];

    int unsigned c_a  [6] = '{255, 255, 5, 5, 16, 16};
    int unsigned c_b  [6] = '{255, 255, 6, 6, 16, 16};
    bit          c_apx[6] = '{0, 1, 0, 1, 0, 1};
    int unsigned c_exp[6] = '{65025, 65021, 30, 30, 256, 256};

    always #5 clk = ~clk;

    rr_mult_pipe_if #(.W(W), .ERR_W(ERR_W)) bus ();

    rr_mult_pipe #(.W(W), .L(L), .APX_K(APX_K), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Approximate product = exact product minus the carries lost in the low APX_K cross-term bits.
    function automatic logic [PW-1:0] ref_prod(input int unsigned a, input int unsigned b, input bit apx);
        int unsigned ah = a >> L;
        int unsigned al = a % (1 << L);
        int unsigned bh = b >> L;
        int unsigned bl = b % (1 << L);
        int unsigned p2 = ah * bl;
        int unsigned p3 = al * bh;
        int unsigned xs;
        int unsigned xa;
        longint unsigned full = 64'(a) * 64'(b);
        if (!apx || APX_K == 0) return PW'(full);
        xs = p2 + p3;
        xa = (((p2 >> APX_K) + (p3 >> APX_K)) << APX_K) | ((p2 | p3) & ((1 << APX_K) - 1));
        return PW'(full - (64'(xs - xa) << L));
    endfunction

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_apx    = 1'b0;
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b0;
    endtask

    // One beat into an idle pipe; reports product, latency in edges, and out_valid one edge later.
    task automatic send_one(input int unsigned a, input int unsigned b, input bit apx,
                            output logic [PW-1:0] p, output logic apxo, output int lat,
                            output logic still_v);
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_a      = W'(a);
        bus.in_b      = W'(b);
        bus.in_apx    = apx;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        p    = bus.out_p;
        apxo = bus.out_apx;
        @(posedge clk); #1;
        still_v = bus.out_valid;
    endtask

    task automatic test_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_p !== '0 || bus.out_apx !== 1'b0)
            begin failures++; $display("FAIL reset_outputs: got v=%0b p=%0d apx=%0b expected 0 0 0", bus.out_valid, bus.out_p, bus.out_apx); end
        checks++;
        if (bus.err_cnt !== '0 || bus.err_max !== '0 || bus.in_ready !== 1'b1)
            begin failures++; $display("FAIL reset_mon: got cnt=%0d max=%0d rdy=%0b expected 0 0 1", bus.err_cnt, bus.err_max, bus.in_ready); end
        rst_n = 1'b1;
        // Fill the pipe, then reset with beats in flight.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1;
            bus.in_a     = W'($urandom);
            bus.in_b     = W'($urandom);
            bus.in_apx   = 1'b1;
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0)
            begin failures++; $display("FAIL reset_async: got out_valid=%0b expected 0", bus.out_valid); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.err_cnt !== '0)
                begin failures++; $display("FAIL reset_flush[%0d]: got v=%0b rdy=%0b cnt=%0d expected 0 1 0", i, bus.out_valid, bus.in_ready, bus.err_cnt); end
        end
        exp_q.delete();
    endtask

    task automatic test_corners();
        logic [PW-1:0] p;
        logic apxo;
        logic still_v;
        int lat;
        int unsigned exp_cnt;
        int unsigned exp_max;
        for (int i = 0; i < 6; i++) begin
            send_one(c_a[i], c_b[i], c_apx[i], p, apxo, lat, still_v);
            checks++;
            if (p !== PW'(c_exp[i]) || apxo !== c_apx[i])
                begin failures++; $display("FAIL corner[%0d] %0d*%0d apx=%0b: got p=%0d apx=%0b expected p=%0d apx=%0b", i, c_a[i], c_b[i], c_apx[i], p, apxo, c_exp[i], c_apx[i]); end
            if (i == 1) begin
`ifdef ERR_MON_EN
                exp_cnt = 1; exp_max = 4;
`else
                exp_cnt = 0; exp_max = 0;
`endif
                checks++;
                if (bus.err_cnt !== ERR_W'(exp_cnt) || bus.err_max !== PW'(exp_max))
                    begin failures++; $display("FAIL corner_err: got cnt=%0d max=%0d expected cnt=%0d max=%0d", bus.err_cnt, bus.err_max, exp_cnt, exp_max); end
            end
        end
        checks++;
        if (bus.err_cnt !== ERR_W'(exp_cnt) || bus.err_max !== PW'(exp_max))
            begin failures++; $display("FAIL corner_noerr: got cnt=%0d max=%0d expected cnt=%0d max=%0d", bus.err_cnt, bus.err_max, exp_cnt, exp_max); end
    endtask

    task automatic test_latency();
        logic [PW-1:0] p;
        logic apxo;
        logic still_v;
        int lat;
        send_one(37, 201, 1'b0, p, apxo, lat, still_v);
        checks++;
        if (lat !== 3)
            begin failures++; $display("FAIL latency: got %0d edges expected 3", lat); end
        checks++;
        if (still_v !== 1'b0)
            begin failures++; $display("FAIL latency_drop: got out_valid=%0b at N+4 expected 0", still_v); end
        checks++;
        if (p !== ref_prod(37, 201, 1'b0))
            begin failures++; $display("FAIL latency_value: got %0d expected %0d", p, ref_prod(37, 201, 1'b0)); end
    endtask

    task automatic test_random_stream();
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        bit acc  = 1'b0;
        logic [PW:0] e;
        localparam int N = 60;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (got < N && cyc < 5000) begin
            if (!bus.in_valid || acc) begin
                if (sent < N && $urandom_range(3) != 0) begin
                    bus.in_valid = 1'b1;
                    bus.in_a     = ($urandom_range(4) == 0) ? W'(255) : W'($urandom);
                    bus.in_b     = ($urandom_range(4) == 0) ? W'(255) : W'($urandom);
                    bus.in_apx   = 1'($urandom);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(9) < 7);
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                got++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL stream_extra: got p=%0d expected no output", bus.out_p);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_apx, bus.out_p} !== e)
                        begin failures++; $display("FAIL stream[%0d]: got p=%0d apx=%0b expected p=%0d apx=%0b", got - 1, bus.out_p, bus.out_apx, e[PW-1:0], e[PW]); end
                end
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                exp_q.push_back({bus.in_apx, ref_prod(bus.in_a, bus.in_b, bus.in_apx)});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (got != N || exp_q.size() != 0)
            begin failures++; $display("FAIL stream_count: got %0d outputs (%0d pending) expected %0d", got, exp_q.size(), N); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        int sent    = 0;
        int got     = 0;
        int cyc     = 0;
        int stalled = 0;
        bit acc        = 1'b0;
        bit prev_stall = 1'b0;
        logic [PW:0]   e;
        logic [PW-1:0] held = '0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (got < 8 && cyc < 200) begin
            if (sent >= 8) begin
                bus.in_valid = 1'b0;
            end else if (!bus.in_valid || acc) begin
                bus.in_valid = 1'b1;
                bus.in_a     = W'($urandom);
                bus.in_b     = W'($urandom);
                bus.in_apx   = 1'($urandom);
            end
            bus.out_ready = !(cyc >= 5 && cyc < 10);
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_p !== held)
                    begin failures++; $display("FAIL b2b_hold: got v=%0b p=%0d expected v=1 p=%0d", bus.out_valid, bus.out_p, held); end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            if (prev_stall) begin
                stalled++;
                held = bus.out_p;
                checks++;
                if (bus.in_ready !== 1'b0)
                    begin failures++; $display("FAIL b2b_in_ready: got %0b while stalled expected 0", bus.in_ready); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                got++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_extra: got p=%0d expected no output", bus.out_p);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_apx, bus.out_p} !== e)
                        begin failures++; $display("FAIL b2b[%0d]: got p=%0d apx=%0b expected p=%0d apx=%0b", got - 1, bus.out_p, bus.out_apx, e[PW-1:0], e[PW]); end
                end
            end
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                exp_q.push_back({bus.in_apx, ref_prod(bus.in_a, bus.in_b, bus.in_apx)});
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (got != 8 || exp_q.size() != 0)
            begin failures++; $display("FAIL b2b_count: got %0d outputs (%0d pending) expected 8", got, exp_q.size()); end
        checks++;
        if (stalled != 5)
            begin failures++; $display("FAIL b2b_stall_cycles: got %0d expected 5", stalled); end
        exp_q.delete();
    endtask

`ifdef ERR_MON_EN
    task automatic test_err_clr();
        int wait_cyc = 0;
        logic [PW-1:0] p;
        logic apxo;
        logic still_v;
        int lat;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_a      = W'(255);
        bus.in_b      = W'(255);
        bus.in_apx    = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        while (!bus.out_valid && wait_cyc < 20) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        checks++;
        if (bus.out_valid !== 1'b1)
            begin failures++; $display("FAIL err_clr_wait: got out_valid=%0b expected 1", bus.out_valid); end
        bus.out_ready = 1'b1;
        bus.err_clr   = 1'b1;
        @(posedge clk); #1;
        bus.err_clr = 1'b0;
        checks++;
        if (bus.err_cnt !== '0 || bus.err_max !== '0)
            begin failures++; $display("FAIL err_clr_wins: got cnt=%0d max=%0d expected 0 0", bus.err_cnt, bus.err_max); end
        send_one(255, 255, 1'b1, p, apxo, lat, still_v);
        checks++;
        if (bus.err_cnt !== ERR_W'(1) || bus.err_max !== PW'(4))
            begin failures++; $display("FAIL err_after_clr: got cnt=%0d max=%0d expected 1 4", bus.err_cnt, bus.err_max); end
    endtask

    task automatic test_err_sat();
        localparam int NSAT = (1 << ERR_W) + 1;
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_a      = W'(255);
        bus.in_b      = W'(255);
        bus.in_apx    = 1'b1;
        bus.out_ready = 1'b1;
        repeat (NSAT) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (bus.err_cnt !== {ERR_W{1'b1}} || bus.err_max !== PW'(4))
            begin failures++; $display("FAIL err_saturate: got cnt=%0d max=%0d expected %0d 4", bus.err_cnt, bus.err_max, (1 << ERR_W) - 1); end
    endtask
`endif

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_corners();
        test_latency();
        test_random_stream();
        test_back_to_back();
`ifdef ERR_MON_EN
        test_err_clr();
        test_err_sat();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
